// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type, and the R-type funct codes the control unit decodes into op.
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_e;

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   // Low two funct bits of MULT..DIVU map directly onto op.
   function automatic op_e funct_to_op(input logic [5:0] funct);
      return op_e'(funct[1:0]);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/command and HI/LO result bundle between the datapath and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, hi_we, lo_we, wdata,
                   input  busy, done, hi, lo);
   modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                   output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; one bit per cycle,
// sign handled by magnitude arithmetic plus a final negate on the HI/LO write.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO accepted here
// MUL   | shift-add multiply, WIDTH iterations
// DIV   | restoring divide, WIDTH iterations
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);

   localparam int                CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;
   logic                 div0_q, div0_d;
   logic                 done_q, done_d;

   logic                 is_signed;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       mul_sum, rem_sh, diff;
   logic [2*WIDTH-1:0]   step_acc, prod;
   logic [WIDTH-1:0]     quo, rem;

   always_comb begin
      is_signed = ~bus.op[0];
      abs_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      abs_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
      diff      = rem_sh - {1'b0, opnd_q};

      step_acc = acc_q;
      case (state_q)
         MUL: step_acc = {mul_sum, acc_q[WIDTH-1:1]};
         // Remainder is always below the divisor, so diff[WIDTH] is a pure borrow flag.
         DIV: step_acc = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
         default: step_acc = acc_q;
      endcase

      prod = neg_res_q ? -step_acc : step_acc;
      quo  = step_acc[WIDTH-1:0];
      rem  = step_acc[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = bus.op[1] ? DIV : MUL;
               cnt_d     = '0;
               neg_res_d = is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               neg_rem_d = is_signed & bus.a[WIDTH-1];
               div0_d    = (bus.b == '0);
               if (bus.op[1]) begin
                  acc_d  = {{WIDTH{1'b0}}, abs_a};
                  opnd_d = abs_b;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, abs_b};
                  opnd_d = abs_a;
               end
            end else begin
               if (bus.hi_we) hi_d = bus.wdata;
               if (bus.lo_we) lo_d = bus.wdata;
            end
         end
         MUL, DIV: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               if (state_q == MUL) begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end else begin
                  // Zero divisor: the magnitude path leaves |a| as remainder, so HI restores a.
                  hi_d = neg_rem_q ? -rem : rem;
                  lo_d = div0_q ? {WIDTH{1'b1}} : (neg_res_q ? -quo : quo);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit: arithmetic corner cases, busy/done timing,
// ignored commands while busy, mid-operation reset, and MTHI/MTLO behaviour.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 64) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Called on a negedge; leaves on the negedge where done is high.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_done_low"}, 32'(bus.done), 32'd0);
      check({tag, "_busy_high"}, 32'(bus.busy), 32'd1);
      wait_idle(n);
      check({tag, "_busy_cycles"}, 32'(n), 32'd32);
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_hi"}, bus.hi, exp_hi);
      check({tag, "_lo"}, bus.lo, exp_lo);
   endtask

   initial begin
      int n;
      int done_cnt;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.a     = '0;
      bus.b     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_hi", bus.hi, 32'd0);
      check("reset_lo", bus.lo, 32'd0);

      // Back-to-back: each run_op launches in the cycle the previous done is high.
      run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_7_2",   OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3);
      run_op("div_zero",   OP_DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF);
      run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("divu_zero",  OP_DIVU,  32'h8000_0001, 32'd0,         32'h8000_0001, 32'hFFFF_FFFF);
      run_op("div_nzero",  OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // Start and MTHI while busy are both ignored; HI/LO hold until the end.
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.a     = 32'd6;
      bus.b     = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      check("hold_done_low", 32'(bus.done), 32'd0);
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 32'd9;
      bus.b     = 32'd3;
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      check("hold_busy", 32'(bus.busy), 32'd1);
      check("hold_hi_mid", bus.hi, 32'hFFFF_FFF9);
      check("hold_lo_mid", bus.lo, 32'hFFFF_FFFF);
      wait_idle(n);
      check("hold_busy_rest", 32'(n), 32'd27);
      check("hold_done", 32'(bus.done), 32'd1);
      check("hold_hi", bus.hi, 32'd0);
      check("hold_lo", bus.lo, 32'd42);

      // Reset mid-operation abandons it without a done pulse.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) done_cnt++;
         @(negedge clk);
      end
      check("rst_no_done", 32'(done_cnt), 32'd0);

      // MTHI in idle, registered with no bypass.
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      #1;
      check("mthi_no_bypass", bus.hi, 32'd0);
      @(negedge clk);
      bus.hi_we = 1'b0;
      check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
      check("mthi_lo", bus.lo, 32'd0);

      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h1111_1111;
      @(negedge clk);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      check("mtboth_hi", bus.hi, 32'h1111_1111);
      check("mtboth_lo", bus.lo, 32'h1111_1111);

      // Start wins over a simultaneous MTLO.
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.a     = 32'd3;
      bus.b     = 32'd4;
      bus.lo_we = 1'b1;
      bus.wdata = 32'hAAAA_AAAA;
      @(negedge clk);
      bus.start = 1'b0;
      bus.lo_we = 1'b0;
      check("startwin_lo_kept", bus.lo, 32'h1111_1111);
      check("startwin_busy", 32'(bus.busy), 32'd1);
      wait_idle(n);
      check("startwin_cycles", 32'(n), 32'd32);
      check("startwin_done", 32'(bus.done), 32'd1);
      check("startwin_hi", bus.hi, 32'd0);
      check("startwin_lo", bus.lo, 32'd12);
      @(negedge clk);
      check("startwin_done_pulse", 32'(bus.done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
